// File: rtl/xcver_reset_ctrl_if.sv
// Transceiver-side status inputs and reset/ready outputs of the reset sequencer.
// The slave modport is the sequencer; the master modport is the wrapper or PCS side.
interface xcver_reset_ctrl_if;
  logic       i_Restart;
  logic       i_PllLocked;
  logic       i_ReconfigBusy;
  logic       i_SyncStatus;
  logic       o_GxBPwrDwn;
  logic       o_RxAnalogRst;
  logic       o_TxDigitalRst;
  logic       o_RxDigitalRst;
  logic       o_TxReady;
  logic       o_RxReady;
  logic [2:0] o3_State;
  logic [7:0] o8_RetryCnt;

  modport slave (
    input  i_Restart, i_PllLocked, i_ReconfigBusy, i_SyncStatus,
    output o_GxBPwrDwn, o_RxAnalogRst, o_TxDigitalRst, o_RxDigitalRst,
    output o_TxReady, o_RxReady, o3_State, o8_RetryCnt
  );

  modport master (
    output i_Restart, i_PllLocked, i_ReconfigBusy, i_SyncStatus,
    input  o_GxBPwrDwn, o_RxAnalogRst, o_TxDigitalRst, o_RxDigitalRst,
    input  o_TxReady, o_RxReady, o3_State, o8_RetryCnt
  );
endinterface

// File: rtl/xcver_reset_ctrl.sv
// SGMII GX transceiver power-up/reset sequencer: powerdown -> PLL lock -> TX release
// -> RX settle -> RX sync, with automatic recovery from lock loss and sync loss.
module xcver_reset_ctrl #(
  parameter int unsigned pPwrDwnCycles   = 16,
  parameter int unsigned pLockTimeout    = 65535,
  parameter int unsigned pRxSettleCycles = 1024,
  parameter int unsigned pSyncLossFilter = 8
) (
  input logic             i_CalClk,
  input logic             i_RstN,
  xcver_reset_ctrl_if.slave xcvr
);

  localparam logic [2:0] ST_PWRDN     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_RX_SETTLE = 3'd2;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  localparam logic [15:0] PD_LAST   = 16'(pPwrDwnCycles - 1);
  localparam logic [15:0] LT_LAST   = 16'(pLockTimeout - 1);
  localparam logic [15:0] RS_LAST   = 16'(pRxSettleCycles - 1);
  localparam logic [7:0]  LOSS_LAST = 8'(pSyncLossFilter - 1);

  // {pwrdn, rx_analog, tx_digital, rx_digital, tx_ready, rx_ready}
  function automatic logic [5:0] st_outputs(input logic [2:0] st);
    case (st)
      ST_WAIT_LOCK: st_outputs = 6'b011100;
      ST_RX_SETTLE: st_outputs = 6'b000110;
      ST_WAIT_SYNC: st_outputs = 6'b000010;
      ST_READY:     st_outputs = 6'b000011;
      default:      st_outputs = 6'b111100;
    endcase
  endfunction

  // synchronizer bit order: {sync, busy, locked}
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  loss_q, loss_d;
  logic [7:0]  retry_q, retry_d;
  logic [5:0]  out_q, out_d;
  logic        locked, busy, sync, enter, retry_inc;

  assign locked = sync2_q[0];
  assign busy   = sync2_q[1];
  assign sync   = sync2_q[2];

  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    retry_inc = 1'b0;
    if (state_q > ST_READY) begin
      state_d = ST_PWRDN;
      enter   = 1'b1;
    end else if (xcvr.i_Restart) begin
      state_d = ST_PWRDN;
      enter   = 1'b1;
    end else if (!locked && state_q >= ST_RX_SETTLE) begin
      state_d   = ST_PWRDN;
      enter     = 1'b1;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        ST_PWRDN:
          if (timer_q == PD_LAST) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end
        ST_WAIT_LOCK:
          // lock wins over a coincident timeout
          if (locked && !busy) begin
            state_d = ST_RX_SETTLE;
            enter   = 1'b1;
          end else if (timer_q == LT_LAST) begin
            state_d   = ST_PWRDN;
            enter     = 1'b1;
            retry_inc = 1'b1;
          end
        ST_RX_SETTLE:
          if (!busy && timer_q == RS_LAST) begin
            state_d = ST_WAIT_SYNC;
            enter   = 1'b1;
          end
        ST_WAIT_SYNC:
          if (sync) begin
            state_d = ST_READY;
            enter   = 1'b1;
          end
        ST_READY:
          if (!sync && loss_q == LOSS_LAST) begin
            state_d = ST_RX_SETTLE;
            enter   = 1'b1;
          end
        default: ;
      endcase
    end

    // reconfig activity during settle restarts the settle count
    if (enter || (state_q == ST_RX_SETTLE && busy)) timer_d = '0;
    else                                            timer_d = timer_q + 16'd1;

    if (enter || state_q != ST_READY || sync) loss_d = '0;
    else                                      loss_d = loss_q + 8'd1;

    retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
    out_d   = st_outputs(state_d);
  end

  always_ff @(posedge i_CalClk) begin
    if (!i_RstN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= ST_PWRDN;
      timer_q <= '0;
      loss_q  <= '0;
      retry_q <= '0;
      out_q   <= st_outputs(ST_PWRDN);
    end else begin
      sync1_q <= {xcvr.i_SyncStatus, xcvr.i_ReconfigBusy, xcvr.i_PllLocked};
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      loss_q  <= loss_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign xcvr.o_GxBPwrDwn    = out_q[5];
  assign xcvr.o_RxAnalogRst  = out_q[4];
  assign xcvr.o_TxDigitalRst = out_q[3];
  assign xcvr.o_RxDigitalRst = out_q[2];
  assign xcvr.o_TxReady      = out_q[1];
  assign xcvr.o_RxReady      = out_q[0];
  assign xcvr.o3_State       = state_q;
  assign xcvr.o8_RetryCnt    = retry_q;

endmodule
